// File: rtl/display_scan_ctrl_if.sv
// Load handshake between a value producer and display_scan_ctrl.
// The master drives load/value; the slave (scan controller) returns ready.
interface display_scan_ctrl_if;
  logic        load;
  logic [15:0] value;
  logic        ready;

  modport master (
    output load,
    output value,
    input  ready
  );

  modport slave (
    input  load,
    input  value,
    output ready
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zeros on digits 3..1.
module display_scan_ctrl #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  display_scan_ctrl_if.slave  bus,
  input  logic                enable,
  output logic [3:0]          number,
  output logic [3:0]          an,
  output logic                frame_tick
);

  localparam int unsigned CntW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] ShowLast  = CntW'(CLK_DIV - BLANK_CYCLES - 1);

  typedef enum logic [0:0] {
    StBlank,
    StShow
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     disp_q, disp_d;
  logic [15:0]     pend_q, pend_d;
  logic            pend_v_q, pend_v_d;
  logic [3:0]      number_q, number_d;
  logic [3:0]      an_q, an_d;
  logic            frame_tick_q, frame_tick_d;

  logic            enter_blank;
  logic            boundary;
  logic [3:0]      nib_d;
  logic [3:0]      lz_d;
  logic            show_d;

  function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] i);
    logic [15:0] s;
    s = v >> {i, 2'b00};
    return s[3:0];
  endfunction

  // Slot timing, digit index and frame boundary detection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    idx_d       = idx_q;
    enter_blank = 1'b0;
    unique case (state_q)
      StBlank: begin
        if (cnt_q == BlankLast) begin
          state_d = StShow;
          cnt_d   = '0;
        end
      end
      StShow: begin
        if (cnt_q == ShowLast) begin
          state_d     = StBlank;
          cnt_d       = '0;
          idx_d       = idx_q + 2'd1;
          enter_blank = 1'b1;
        end
      end
      default: begin
        state_d = StBlank;
        cnt_d   = '0;
      end
    endcase
    boundary = enter_blank && (idx_d == 2'd0);
  end

  // Double buffer: the pending value is promoted only at a frame boundary.
  always_comb begin
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_v_d     = pend_v_q;
    frame_tick_d = boundary;
    if (boundary && pend_v_q) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
    end
    if (bus.load && !pend_v_q) begin
      pend_d   = bus.value;
      pend_v_d = 1'b1;
    end
  end

  // Leading-zero mask per digit, computed on the value that will be shown.
  always_comb begin
    lz_d = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    lz_d[3] = (disp_d[15:12] == 4'd0);
    lz_d[2] = lz_d[3] && (disp_d[11:8] == 4'd0);
    lz_d[1] = lz_d[2] && (disp_d[7:4] == 4'd0);
`endif
  end

  // Registered decoder input and anode drive, both derived from next-state values.
  always_comb begin
    nib_d    = nibble(disp_d, idx_d);
    number_d = number_q;
    if (enter_blank) begin
      number_d = nib_d;
    end
    show_d = (state_d == StShow) && enable && (nib_d <= 4'd9) && !lz_d[idx_d];
    an_d   = show_d ? ~(4'b0001 << idx_d) : 4'b1111;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StBlank;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      disp_q       <= 16'h0000;
      pend_q       <= 16'h0000;
      pend_v_q     <= 1'b0;
      number_q     <= 4'd0;
      an_q         <= 4'b1111;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      number_q     <= number_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.ready  = ~pend_v_q;
  assign number     = number_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized self-checking bench for display_scan_ctrl against a frame-phase reference model.
module tb_display_scan_ctrl;
  localparam int unsigned ClkDiv = 8;
  localparam int unsigned Blank  = 2;
  localparam int unsigned Frame  = 4 * ClkDiv;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b1;
  logic [3:0] number;
  logic [3:0] an;
  logic       frame_tick;

  int n_cmp = 0;
  int n_err = 0;

  display_scan_ctrl_if bus ();

  display_scan_ctrl #(
    .CLK_DIV      (ClkDiv),
    .BLANK_CYCLES (Blank)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .enable     (enable),
    .number     (number),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  // Reference model: time since reset decides the slot; disp/pend follow the buffer rules.
  int unsigned t_m;
  logic [15:0] disp_m, pend_m;
  bit          pend_v_m, en_m;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      t_m      <= 0;
      disp_m   <= 16'h0000;
      pend_m   <= 16'h0000;
      pend_v_m <= 1'b0;
      en_m     <= 1'b0;
    end else begin
      t_m  <= t_m + 1;
      en_m <= enable;
      if (((t_m + 1) % Frame) == 0 && pend_v_m) begin
        disp_m   <= pend_m;
        pend_v_m <= 1'b0;
      end else if (bus.load && !pend_v_m) begin
        pend_m   <= bus.value;
        pend_v_m <= 1'b1;
      end
    end
  end

  // Expected {an, number, ready, frame_tick}.
  function automatic logic [9:0] exp_vec();
    int unsigned p, d, pos;
    logic [3:0]  nib, ea;
    bit          lz;
    p   = t_m % Frame;
    d   = p / ClkDiv;
    pos = p % ClkDiv;
    nib = disp_m[4*d +: 4];
    lz  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    lz = (d > 0) && ((disp_m >> (4 * d)) == 16'h0000);
`endif
    ea = (pos >= Blank && en_m && nib <= 4'd9 && !lz) ? ~(4'b0001 << d) : 4'b1111;
    return {ea, nib, !pend_v_m, (t_m != 0) && (t_m % Frame == 0)};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    bus.load = 1'b0;
    bus.value = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({an, number, bus.ready, frame_tick} !== {4'b1111, 4'd0, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL reset_hold: got an=%b num=%h rdy=%b tick=%b, want an=1111 num=0 rdy=1 tick=0",
                 an, number, bus.ready, frame_tick);
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({an, number, bus.ready, frame_tick} !== exp_vec()) begin
        n_err++;
        $display("FAIL reset_scan t=%0d: got an=%b num=%h rdy=%b tick=%b, want %b",
                 t_m, an, number, bus.ready, frame_tick, exp_vec());
      end
      if (t_m == 2 || t_m == 10 || t_m == 18 || t_m == 26) begin
        n_cmp++;
        if (an !== ~(4'b0001 << ((t_m - 2) / 8))) begin
          n_err++;
          $display("FAIL first_anodes t=%0d: got an=%b", t_m, an);
        end
      end
      if (t_m == 32 || t_m == 64) begin
        n_cmp++;
        if (frame_tick !== 1'b1) begin
          n_err++;
          $display("FAIL tick_period t=%0d: got tick=%b want 1", t_m, frame_tick);
        end
      end
    end
  endtask

  task automatic test_load();
    int unsigned at;
    at = $urandom_range(3, 20);
    for (int i = 0; i < 3 * Frame; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({an, number, bus.ready, frame_tick} !== exp_vec()) begin
        n_err++;
        $display("FAIL load_1234 t=%0d: got an=%b num=%h rdy=%b tick=%b, want %b",
                 t_m, an, number, bus.ready, frame_tick, exp_vec());
      end
      bus.load  = (i == at);
      bus.value = 16'h1234;
    end
    bus.load = 1'b0;
  endtask

  task automatic test_ignored_load();
    for (int i = 0; i < 3 * Frame; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({an, number, bus.ready, frame_tick} !== exp_vec()) begin
        n_err++;
        $display("FAIL ignored_load t=%0d: got an=%b num=%h rdy=%b tick=%b, want %b",
                 t_m, an, number, bus.ready, frame_tick, exp_vec());
      end
      bus.load  = (i == 3) || (i == 6);
      bus.value = (i == 3) ? 16'h1234 : 16'h9999;
    end
    bus.load = 1'b0;
    n_cmp++;
    if (disp_m !== 16'h1234) begin
      n_err++;
      $display("FAIL ignored_load_model: got disp=%h want 1234", disp_m);
    end
  endtask

  task automatic test_invalid();
    for (int i = 0; i < 3 * Frame; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({an, number, bus.ready, frame_tick} !== exp_vec()) begin
        n_err++;
        $display("FAIL invalid_00a5 t=%0d: got an=%b num=%h rdy=%b tick=%b, want %b",
                 t_m, an, number, bus.ready, frame_tick, exp_vec());
      end
      bus.load  = (i == 2);
      bus.value = 16'h00A5;
    end
    bus.load = 1'b0;
  endtask

  task automatic test_enable();
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({an, number, bus.ready, frame_tick} !== exp_vec()) begin
        n_err++;
        $display("FAIL enable_gate t=%0d: got an=%b num=%h rdy=%b tick=%b, want %b",
                 t_m, an, number, bus.ready, frame_tick, exp_vec());
      end
      if (i > 5 && i <= 45) begin
        n_cmp++;
        if (an !== 4'b1111) begin
          n_err++;
          $display("FAIL enable_dark t=%0d: got an=%b want 1111", t_m, an);
        end
      end
      enable = !(i >= 5 && i < 45);
    end
    enable = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({an, number, bus.ready, frame_tick} !== exp_vec()) begin
        n_err++;
        $display("FAIL random t=%0d: got an=%b num=%h rdy=%b tick=%b, want %b",
                 t_m, an, number, bus.ready, frame_tick, exp_vec());
      end
      bus.load  = ($urandom_range(0, 3) == 0);
      bus.value = 16'($urandom);
      if ($urandom_range(0, 15) == 0) enable = !enable;
    end
    bus.load = 1'b0;
    enable   = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 3 * Frame && !hit; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({an, number, bus.ready, frame_tick} !== exp_vec()) begin
        n_err++;
        $display("FAIL reset_mid_pre t=%0d: got an=%b num=%h rdy=%b tick=%b, want %b",
                 t_m, an, number, bus.ready, frame_tick, exp_vec());
      end
      bus.load  = (t_m % Frame == 1) && !pend_v_m;
      bus.value = 16'h4321;
      if (pend_v_m && (t_m % ClkDiv) >= Blank) hit = 1'b1;
    end
    bus.load = 1'b0;
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL reset_mid_setup: got no SHOW slot with pending value, want one");
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({an, number, bus.ready} !== {4'b1111, 4'd0, 1'b1}) begin
      n_err++;
      $display("FAIL async_reset: got an=%b num=%h rdy=%b, want an=1111 num=0 rdy=1",
               an, number, bus.ready);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 2 * Frame + 4; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({an, number, bus.ready, frame_tick} !== exp_vec()) begin
        n_err++;
        $display("FAIL reset_mid_post t=%0d: got an=%b num=%h rdy=%b tick=%b, want %b",
                 t_m, an, number, bus.ready, frame_tick, exp_vec());
      end
    end
  endtask

  initial begin
    bus.load  = 1'b0;
    bus.value = 16'h0000;
    test_reset();
    test_load();
    test_ignored_load();
    test_invalid();
    test_enable();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing scan controller for a 4-digit common-anode 7-segment display. It accepts a 16-bit BCD value through a load handshake and double-buffers it so updates land only on frame boundaries. It drives the 4-bit `number` input of the registered 7-segment decoder together with active-low digit anodes. Each digit slot opens with a blanking interval that covers the decoder's one-cycle latency and prevents ghosting.

## Interface

Parameters:
- `CLK_DIV`, default 50000: clock cycles per digit slot (blank plus show). Must be greater than `BLANK_CYCLES`.
- `BLANK_CYCLES`, default 16: cycles with all anodes off at the start of each slot. Must be at least 1.

Ports:
- `clock`  in  1  system clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `load`  in  1  request to accept `value`; sampled only when `ready`=1
- `value`  in  16  four BCD nibbles; `[3:0]` is digit 0 (rightmost), `[15:12]` is digit 3
- `enable`  in  1  0 forces all anodes off; scanning continues
- `ready`  out  1  1 = pending buffer empty, `load` is accepted
- `number`  out  4  BCD digit to the decoder
- `an`  out  4  active-low anode enables; `an[k]` selects digit k
- `frame_tick`  out  1  one-cycle pulse at each frame start

## Operation

- Registers:
  - `disp` (16 bits): shown value
  - `pend` (16 bits) with `pend_v`: pending value and its valid flag
  - `idx` (2 bits): current digit
  - `cnt`: slot cycle counter
  - `state`: BLANK or SHOW
- Reset values (asynchronous, immediate):
  - outputs: `number`=0, `an`=4'b1111, `ready`=1, `frame_tick`=0
  - internal: `state`=BLANK, `idx`=0, `cnt`=0, `disp`=0, `pend`=0, `pend_v`=0
- Handshake:
  - `load`=1 while `ready`=1 captures `value` into `pend`, sets `pend_v`, and drops `ready` on the same edge.
  - `load` while `ready`=0 is ignored; the value is not queued.
- FSM:
  - BLANK: `an`=1111. `cnt` counts 0 to `BLANK_CYCLES`-1, then moves to SHOW with `cnt`=0.
  - SHOW: `an[idx]`=0 and all other anodes 1, subject to the `enable`, invalid-digit and blanking rules. `cnt` counts 0 to `CLK_DIV`-`BLANK_CYCLES`-1, then `idx`←`idx`+1 (mod 4) and the FSM moves to BLANK.
- Each entry into BLANK registers `number`←`disp` nibble at the new `idx`.
- Frame boundary is entry into BLANK with new `idx`=0:
  - If `pend_v`: `disp`←`pend`, `pend_v`←0, `ready`←1. `number` takes the new `disp[3:0]` on the same edge.
  - `frame_tick`=1 for the cycle following that edge.
- Simultaneous events:
  - `load` in the boundary cycle while `pend_v`=1 is ignored, because `ready` is still 0.
  - `load` in the boundary cycle while `pend_v`=0 is captured and shows next frame.
- Invalid nibble (value >9): that digit's anode stays 1 for the whole slot; `number` is still driven with the raw nibble.
- `enable`=0: `an` is registered to 1111 on the next edge; `idx`, `cnt` and the handshake are unaffected.
- Reset mid-operation: `pend` is discarded and the display goes dark immediately.

## Timing

- Frame = 4×`CLK_DIV` cycles. `frame_tick` period = 4×`CLK_DIV`.
- The decoder registers `number` one cycle after it changes. With `BLANK_CYCLES` ≥ 1, segments are settled before the anode asserts.
- `an` and `number` are registered outputs with no combinational path from inputs.
- Load-to-display latency is 1 to 4×`CLK_DIV` cycles, depending on frame phase.
- After reset release: `cnt` starts at 0 in BLANK with `idx`=0. The first `an`=1110 appears `BLANK_CYCLES` cycles after the first active edge.

## Configuration

- `LEADING_ZERO_BLANK_EN` defined:
  - Digits 3..1 whose nibble is 0 and whose every more-significant nibble is also 0 keep their anode off during SHOW.
  - Digit 0 always shows. Example: 0x0007 shows "   7"; 0x0000 shows "   0".
- Undefined: every valid nibble is shown, including leading zeros.

## Test plan

All tests use `CLK_DIV`=8, `BLANK_CYCLES`=2, `enable`=1.
- Reset: hold `reset_n`=0 → `an`=1111, `ready`=1, `number`=0. Release → `an`=1110 at cycle 2, 1101 at cycle 10, 1011 at 18, 0111 at 26, `frame_tick` period 32.
- Load 16'h1234 mid-frame → `ready`=0 next cycle. At the next boundary `ready`=1 and `number` sequences 4,3,2,1, each with its anode low for 6 cycles.
- Second `load` of 16'h9999 while `ready`=0 → ignored. The display shows 1234, not 9999, after the boundary.
- Load 16'h00A5 → digit 1 (A) anode stays high in its slot. Digits 2 and 3 show 0, or stay blanked with `LEADING_ZERO_BLANK_EN`.
- Drop `enable` to 0 for 40 cycles → `an`=1111 throughout. After `enable` returns to 1, scan phase and `frame_tick` timing are unchanged.
- Assert `reset_n`=0 during SHOW with `pend_v`=1 → `an`=1111 asynchronously. After release, `disp`=0 and the pending value is never displayed.
